// File: rtl/decode_pkg.sv
// Shared field positions, immediate-mode encoding and register-file sizing
// for the custom 32-bit ISA decode stage.
package decode_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int IMMB     = 26;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 23;
  localparam int RS1_MSB  = 22;
  localparam int RS1_LSB  = 19;
  localparam int RS2_MSB  = 18;
  localparam int RS2_LSB  = 15;
  localparam int MODE_MSB = 17;
  localparam int MODE_LSB = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int BOFF_MSB = 26;
  localparam int BOFF_LSB = 0;

  localparam int REG_AW = 4;
  localparam int NREGS  = 16;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_HI   = 2'b10,
    IMM_RSVD = 2'b11
  } imm_mode_t;

endpackage

// File: rtl/decode_stage_reg_scoreboard.sv
// Busy-register scoreboard: issue sets, writeback clears (set wins),
// r0 never busy, plus the combinational hazard lookup for the held instruction.
module reg_scoreboard
  import decode_pkg::*;
#(
  parameter int NWB = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_AW-1:0]     set_rd,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [REG_AW*NWB-1:0] wb_rd,
  input  logic [REG_AW-1:0]     rs1,
  input  logic [REG_AW-1:0]     rs2,
  input  logic [REG_AW-1:0]     rd,
  input  logic                  use_rs2,
  input  logic                  use_rd,
  output logic                  hazard
);

  logic [NREGS-1:0] busy;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    if (gi == 0) begin : g_r0
      assign busy[gi] = 1'b0;
    end else begin : g_rn
      logic bit_reg;
      logic clr;
      logic set;

      always_comb begin
        clr = 1'b0;
        for (int w = 0; w < NWB; w++) begin
          if (wb_valid[w] && (wb_rd[w*REG_AW +: REG_AW] == REG_AW'(gi))) begin
            clr = 1'b1;
          end
        end
      end

      assign set = set_en && (set_rd == REG_AW'(gi));

      // A new producer issuing in the same cycle as an older writeback keeps the bit set.
      always_ff @(posedge clk) begin
        if (rst) begin
          bit_reg <= 1'b0;
        end else if (set) begin
          bit_reg <= 1'b1;
        end else if (clr) begin
          bit_reg <= 1'b0;
        end
      end

      assign busy[gi] = bit_reg;
    end
  end

  assign hazard = busy[rs1] || (use_rs2 && busy[rs2]) || (use_rd && busy[rd]);

endmodule

// File: rtl/decode_stage.sv
// ID pipeline register: decodes fetch beats into fields, immediate and branch
// target, and issues them to execute once the scoreboard reports no hazard.
module decode_stage
  import decode_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NWB        = 1,
  parameter logic [31:0] NODEST_OPS = 32'h0,
  parameter logic [31:0] BRANCH_OPS = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [XLEN-1:0]       pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            opcode,
  output logic                  immediate_bit,
  output logic [REG_AW-1:0]     rd,
  output logic [REG_AW-1:0]     rs1,
  output logic [REG_AW-1:0]     rs2,
  output logic [XLEN-1:0]       immx,
  output logic [XLEN-1:0]       branch_tgt,
  output logic                  illegal,
  input  logic [NWB-1:0]        wb_valid,
  input  logic [REG_AW*NWB-1:0] wb_rd
);

  // Without any branch opcode the target is never consumed, so it stays at zero.
  localparam bit ANY_BRANCH = |BRANCH_OPS;

  logic                held_reg;
  logic [4:0]          opcode_reg;
  logic                immb_reg;
  logic [REG_AW-1:0]   rd_reg;
  logic [REG_AW-1:0]   rs1_reg;
  logic [REG_AW-1:0]   rs2_reg;
  logic [XLEN-1:0]     immx_reg;
  logic [XLEN-1:0]     tgt_reg;
  logic                illegal_reg;

  imm_mode_t           mode_d;
  logic [15:0]         imm16;
  logic [XLEN-1:0]     immx_d;
  logic                illegal_d;
  logic [XLEN-1:0]     boff;
  logic [XLEN-1:0]     tgt_d;

  logic hazard;
  logic issue;
  logic issue_eff;
  logic capture;
  logic nodest;

  assign mode_d = imm_mode_t'(inst[MODE_MSB:MODE_LSB]);
  assign imm16  = inst[IMM_MSB:IMM_LSB];

  always_comb begin
    immx_d    = '0;
    illegal_d = 1'b0;
    case (mode_d)
      IMM_SEXT: immx_d = XLEN'($signed(imm16));
      IMM_ZEXT: immx_d = XLEN'(imm16);
      IMM_HI:   immx_d = XLEN'({imm16, 16'h0000});
      IMM_RSVD: illegal_d = 1'b1;
      default:  illegal_d = 1'b1;
    endcase
  end

  assign boff  = XLEN'($signed(inst[BOFF_MSB:BOFF_LSB])) << 2;
  assign tgt_d = pc + boff;

  assign nodest    = NODEST_OPS[opcode_reg];
  assign out_valid = held_reg && !hazard;
  assign issue     = out_valid && out_ready;
  assign issue_eff = issue && !flush;
  assign in_ready  = !held_reg || issue || flush;
  assign capture   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_reg    <= 1'b0;
      opcode_reg  <= '0;
      immb_reg    <= 1'b0;
      rd_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      immx_reg    <= '0;
      tgt_reg     <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (flush) begin
        held_reg <= 1'b0;
      end else if (capture) begin
        held_reg <= 1'b1;
      end else if (issue) begin
        held_reg <= 1'b0;
      end

      if (capture) begin
        opcode_reg  <= inst[OPC_MSB:OPC_LSB];
        immb_reg    <= inst[IMMB];
        rd_reg      <= inst[RD_MSB:RD_LSB];
        rs1_reg     <= inst[RS1_MSB:RS1_LSB];
        rs2_reg     <= inst[RS2_MSB:RS2_LSB];
        immx_reg    <= immx_d;
        tgt_reg     <= ANY_BRANCH ? tgt_d : '0;
        illegal_reg <= illegal_d;
      end
    end
  end

  reg_scoreboard #(
    .NWB(NWB)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_eff && !nodest),
    .set_rd   (rd_reg),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .rs1      (rs1_reg),
    .rs2      (rs2_reg),
    .rd       (rd_reg),
    .use_rs2  (!immb_reg),
    .use_rd   (!nodest),
    .hazard   (hazard)
  );

  assign opcode        = opcode_reg;
  assign immediate_bit = immb_reg;
  assign rd            = rd_reg;
  assign rs1           = rs1_reg;
  assign rs2           = rs2_reg;
  assign immx          = immx_reg;
  assign branch_tgt    = tgt_reg;
  assign illegal       = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, immediates, branch targets,
// scoreboard stalls, backpressure, flush and mid-run reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  opcode;
  logic        immediate_bit;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [31:0] immx;
  logic [31:0] branch_tgt;
  logic        illegal;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN       (32),
    .NWB        (2),
    .NODEST_OPS (32'h0000_0006),
    .BRANCH_OPS (32'h0000_0002)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inst          (inst),
    .pc            (pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opcode        (opcode),
    .immediate_bit (immediate_bit),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .immx          (immx),
    .branch_tgt    (branch_tgt),
    .illegal       (illegal),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [18:0] low);
    return {op, d, s1, low};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    inst = i;
    pc = p;
    in_valid = 1'b1;
    $display("send inst=%h pc=%h in_ready=%0b", i, p, in_ready);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [3:0] b, input logic [1:0] v);
    wb_valid = v;
    wb_rd = {b, a};
    $display("writeback valid=%b rd0=%0d rd1=%0d", v, a, b);
    tick();
    wb_valid = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = 32'h0; pc = 32'h0; wb_valid = 2'b00; wb_rd = 8'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++; if (immx !== 32'h0) begin errors++; $display("FAIL reset_immx: got %h expected 0", immx); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b expected 0", illegal); end
    checks++; if (opcode !== 5'd0 || rd !== 4'd0) begin errors++; $display("FAIL reset_fields: got op=%0d rd=%0d expected 0/0", opcode, rd); end
  endtask

  task automatic test_capture();
    send(32'h0008_FFFF, 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL capture_valid: got %0b expected 1", out_valid); end
    checks++; if (immx !== 32'hFFFF_FFFF) begin errors++; $display("FAIL capture_immx: got %h expected ffffffff", immx); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL capture_illegal: got %0b expected 0", illegal); end
    checks++; if (rs1 !== 4'd1 || rs2 !== 4'd1 || opcode !== 5'd0) begin errors++; $display("FAIL capture_fields: got rs1=%0d rs2=%0d op=%0d expected 1/1/0", rs1, rs2, opcode); end
    issue_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL capture_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_imm_modes();
    send(mk(5'd0, 4'd0, 4'd0, 19'h08001), 32'h0);
    checks++; if (immx !== 32'hFFFF_8001) begin errors++; $display("FAIL imm_sext: got %h expected ffff8001", immx); end
    issue_one();
    send(mk(5'd0, 4'd0, 4'd0, 19'h18001), 32'h0);
    checks++; if (immx !== 32'h0000_8001) begin errors++; $display("FAIL imm_zext: got %h expected 00008001", immx); end
    issue_one();
    send(mk(5'd0, 4'd0, 4'd0, 19'h28001), 32'h0);
    checks++; if (immx !== 32'h8001_0000 || illegal !== 1'b0) begin errors++; $display("FAIL imm_hi: got %h ill=%0b expected 80010000 ill=0", immx, illegal); end
    issue_one();
    send(mk(5'd0, 4'd0, 4'd0, 19'h38001), 32'h0);
    checks++; if (immx !== 32'h0 || illegal !== 1'b1) begin errors++; $display("FAIL imm_rsvd: got %h ill=%0b expected 0 ill=1", immx, illegal); end
    issue_one();
  endtask

  task automatic test_branch();
    send(32'h0FFF_FFFF, 32'h0000_0100);
    checks++; if (branch_tgt !== 32'h0000_00FC || opcode !== 5'd1) begin errors++; $display("FAIL branch_back: got %h op=%0d expected 000000fc op=1", branch_tgt, opcode); end
    issue_one();
    send(32'h0800_0001, 32'hFFFF_FFFC);
    checks++; if (branch_tgt !== 32'h0) begin errors++; $display("FAIL branch_wrap: got %h expected 0", branch_tgt); end
    issue_one();
  endtask

  task automatic test_raw();
    send(mk(5'd3, 4'd3, 4'd0, 19'h0), 32'h0);
    issue_one();
    send(mk(5'd3, 4'd4, 4'd3, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_stall: got %0b expected 0", out_valid); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_hold: got ov=%0b ir=%0b expected 0/0", out_valid, in_ready); end
    wb(4'd3, 4'd0, 2'b01);
    checks++; if (out_valid !== 1'b1 || rd !== 4'd4) begin errors++; $display("FAIL raw_release: got ov=%0b rd=%0d expected 1/4", out_valid, rd); end
    tick();
    out_ready = 1'b0;
    send(mk(5'd3, 4'd3, 4'd0, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL setwin_ready: got %0b expected 1", out_valid); end
    out_ready = 1'b1;
    wb(4'd3, 4'd0, 2'b01);
    out_ready = 1'b0;
    send(mk(5'd3, 4'd0, 4'd3, 19'h0), 32'h0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setwin_busy: got %0b expected 0", out_valid); end
    wb(4'd3, 4'd0, 2'b01);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL setwin_clear: got %0b expected 1", out_valid); end
    issue_one();
    wb(4'd4, 4'd0, 2'b01);
  endtask

  task automatic test_backpressure();
    send(mk(5'd3, 4'd6, 4'd1, 19'h00123), 32'h0);
    inst = mk(5'd3, 4'd7, 4'd0, 19'h0);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rd !== 4'd6 || immx !== 32'h123) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%0b ir=%0b rd=%0d immx=%h expected 1/0/6/00000123", c, out_valid, in_ready, rd, immx);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (rd !== 4'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_capture: got rd=%0d ov=%0b expected 7/1", rd, out_valid); end
    tick();
    out_ready = 1'b0;
    send(mk(5'd3, 4'd0, 4'd6, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_busy6: got %0b expected 0", out_valid); end
    wb(4'd6, 4'd7, 2'b11);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_dual_wb: got %0b expected 1", out_valid); end
    issue_one();
  endtask

  task automatic test_flush();
    send(mk(5'd3, 4'd5, 4'd0, 19'h0), 32'h0);
    issue_one();
    send(mk(5'd3, 4'd8, 4'd0, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %0b expected 1", out_valid); end
    inst = mk(5'd3, 4'd9, 4'd0, 19'h0);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b expected 1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0b expected 0", out_valid); end
    send(mk(5'd3, 4'd0, 4'd8, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_no_set: got %0b expected 1", out_valid); end
    issue_one();
    send(mk(5'd3, 4'd0, 4'd5, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy5: got %0b expected 0", out_valid); end
    wb(4'd5, 4'd0, 2'b01);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_wb5: got %0b expected 1", out_valid); end
    issue_one();
  endtask

  task automatic test_reset_mid();
    send(mk(5'd3, 4'd10, 4'd0, 19'h0), 32'h0);
    issue_one();
    send(mk(5'd3, 4'd11, 4'd10, 19'h0), 32'h0);
    rst = 1'b1;
    wb_valid = 2'b01; wb_rd = 8'h0A;
    tick();
    rst = 1'b0; wb_valid = 2'b00;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd !== 4'd0) begin errors++; $display("FAIL rstmid_state: got ov=%0b ir=%0b rd=%0d expected 0/1/0", out_valid, in_ready, rd); end
    send(mk(5'd3, 4'd0, 4'd10, 19'h0), 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_busy_clear: got %0b expected 1", out_valid); end
    issue_one();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_imm_modes();
    test_branch();
    test_raw();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the 32-bit custom ISA. It sits between fetch and execute.
- Splits each instruction into its fields and produces an extended immediate (four modes) and a PC-relative branch target.
- Holds the result in an ID pipeline register with valid/ready handshakes on both sides.
- Stalls issue on register hazards via an internal busy-register scoreboard cleared by writeback; honours pipeline flush.

## Interface
Parameters:
- XLEN, 32: width of pc, immx, branch_tgt (32 or 64).
- NWB, 1: number of writeback clear ports (1–2).
- NODEST_OPS, 32'h0: bit n set → opcode n writes no destination.
- BRANCH_OPS, 32'h0: bit n set → opcode n is a branch (branch_tgt meaningful).

Ports (clock and reset first):
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard held and incoming instruction.
- in_valid  in  1  fetch offers inst/pc.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  instruction word.
- pc  in  XLEN  address of inst.
- out_valid  out  1  decoded instruction issuable.
- out_ready  in  1  execute accepts.
- opcode  out  5  inst[31:27].
- immediate_bit  out  1  inst[26]; 1 → rs2 unused.
- rd / rs1 / rs2  out  4 each  inst[26:23] / [22:19] / [18:15].
- immx  out  XLEN  extended immediate.
- branch_tgt  out  XLEN  branch target.
- illegal  out  1  reserved immediate mode (inst[17:16]==2'b11).
- wb_valid  in  NWB  writeback clear strobe, one bit per port.
- wb_rd  in  4*NWB  writeback register per port.

## Operation
- Capture: on in_valid && in_ready && !flush, all decoded fields are computed combinationally from inst/pc and registered; the held flag is set.
- Immediate mode, taken from inst[17:16], with imm = inst[15:0]:
  - 00 → sign-extend imm to XLEN.
  - 01 → zero-extend.
  - 10 → imm << 16, zero-filled, upper bits zero.
  - 11 → zero, illegal=1.
- branch_tgt = pc + (sign-extend(inst[26:0]) << 2), modulo 2^XLEN. It is computed for every instruction; it is meaningful only when BRANCH_OPS[opcode].
- Scoreboard: busy[15:0]. Register 0 is never busy; setting busy[0] is ignored.
- Hazard is asserted when busy[rs1], when busy[rs2] && !immediate_bit, or when busy[rd] && !NODEST_OPS[opcode] (WAW).
- out_valid = held && !hazard.
- Issue is out_valid && out_ready. On issue:
  - busy[rd] is set unless NODEST_OPS[opcode] or rd==0.
  - held clears unless a new instruction is captured in the same cycle.
- Writeback: wb_valid[i] clears busy[wb_rd[i]] at the edge. No same-cycle bypass: the cleared bit is visible the next cycle.
- Simultaneous set and clear of the same register: set wins.
- in_ready = !held || issue || flush.
- flush:
  - held clears next cycle and the incoming beat is dropped (in_ready=1).
  - An issue in the same cycle is cancelled, so busy is not set.
  - busy is not touched by flush: in-flight instructions still write back.

## Timing
- Reset values: held=0, busy=0, out_valid=0, all field outputs 0, illegal=0. in_ready=1 in the first cycle after reset.
- Latency: capture at edge N → out_valid in cycle N+1 if no hazard.
- Throughput: 1 instruction/cycle with back-to-back issue.
- Effective states are EMPTY (held=0) and FULL (held=1). FULL with hazard is STALL, where out_valid=0.
  - EMPTY→FULL on capture.
  - FULL→EMPTY on issue without capture, or on flush.
  - FULL→FULL on issue+capture or on stall.
- Outputs are stable while out_valid && !out_ready.
- Dependent instruction: producer issues at edge N, so busy is set at N and the dependent stalls. Writeback at edge M clears busy, and the dependent issues no earlier than cycle M.
- Reset mid-operation: everything returns to reset values at the next edge; pending wb strobes in that cycle are ignored.

## Structure
- Package decode_pkg holds:
  - Field position constants (OPC_MSB/LSB, IMMB, RD/RS1/RS2 positions, IMM16, BOFF27).
  - The imm_mode_t enum {IMM_SEXT, IMM_ZEXT, IMM_HI, IMM_RSVD}.
  - REG_AW=4 and NREGS=16.
- One sub-module, reg_scoreboard, owns busy[], set/clear priority, the r0 rule, and the hazard lookups.

## Test plan
- Reset, then inst=32'h0_0008_FFFF, mode 00 → one cycle later out_valid=1, immx=32'hFFFF_FFFF, illegal=0.
- Immediate modes: inst[17:16]=01, imm=16'h8001 → immx=32'h0000_8001. Mode 10 → immx=32'h8001_0000. Mode 11 → immx=0, illegal=1.
- Branch: pc=32'h100, inst[26:0]=27'h7FF_FFFF (−1), BRANCH_OPS set → branch_tgt=32'h0FC. pc=32'hFFFF_FFFC, offset +1 → branch_tgt=32'h0 (wrap).
- RAW stall: issue I1 writing r3, then I2 reading rs1=r3 → out_valid=0 until wb_valid/wb_rd=3. Assert wb at edge M; I2 issues in cycle M. The same test with wb_rd=3 coincident with a new r3 set leaves busy[3]=1.
- Backpressure: hold out_ready=0 for 4 cycles → outputs stable, in_ready=0, no busy change. Release → issue and capture in the same cycle.
- Flush with held instruction and in_valid=1 → next cycle out_valid=0, no busy bit set, pending busy[5] still clears on later writeback.
